// File: rtl/instr_fetch_unit_if.sv
// ----------------------------------------------------------------------------
// instr_fetch_unit_if
// Purpose : opcode/funct handshake bus between the instruction fetch unit
//           (producer, master) and the control decoder (consumer, slave).
// Signals : instr  [31:0]      current instruction word
//           opcode [5:0]       instr[31:26]
//           funct  [5:0]       instr[5:0]
//           valid              instr/opcode/funct/pc valid for the decoder
//           ready              decoder accepts the current instruction
//           pc     [ADDR_W-1:0] address of the instruction held in instr
// ----------------------------------------------------------------------------
interface instr_fetch_unit_if #(
   parameter int ADDR_W = 5
);

   logic [31:0]       instr;
   logic [5:0]        opcode;
   logic [5:0]        funct;
   logic              valid;
   logic              ready;
   logic [ADDR_W-1:0] pc;

   modport master (
      output instr,
      output opcode,
      output funct,
      output valid,
      output pc,
      input  ready
   );

   modport slave (
      input  instr,
      input  opcode,
      input  funct,
      input  valid,
      input  pc,
      output ready
   );

endinterface

// File: rtl/instr_fetch_unit.sv
// ----------------------------------------------------------------------------
// instr_fetch_unit
// Purpose : small loadable instruction memory plus program counter sequencer
//           that issues 32-bit instruction words to the control decoder over
//           a valid/ready handshake and stops on HALT_WORD.
// Ports   : clk, rst        clock and asynchronous active-high reset
//           start           begin execution at address 0 (IDLE/DONE only)
//           ld_we/ld_addr/ld_data  loader write port (IDLE/DONE only)
//           busy            high in FETCH or ISSUE
//           done            high in DONE (HALT reached)
//           retired_cnt     accepted-instruction counter (INSTR_COUNT_EN only)
//           dec             master side of instr_fetch_unit_if
// Options : define INSTR_COUNT_EN to add the retired_cnt output and counter.
// ----------------------------------------------------------------------------
module instr_fetch_unit #(
   parameter int          ADDR_W    = 5,
   parameter logic [31:0] HALT_WORD = 32'h0000_000D
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              ld_we,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [31:0]       ld_data,
   output logic              busy,
   output logic              done,
`ifdef INSTR_COUNT_EN
   output logic [15:0]       retired_cnt,
`endif
   instr_fetch_unit_if.master dec
);

   localparam int DEPTH = 2 ** ADDR_W;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      ISSUE = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t            r_state;
   state_t            w_nextState;
   logic [ADDR_W-1:0] r_pc;
   logic [31:0]       r_ir;
   logic [31:0]       r_mem [DEPTH];

   logic w_isHalt;
   logic w_valid;
   logic w_startAccept;
   logic w_pcInc;
   logic w_ldEn;

   // The HALT check looks straight at the instruction register so that a
   // HALT word never produces a valid pulse, not even for one cycle.
   assign w_isHalt = (r_ir == HALT_WORD);

   // The loader only owns the memory while the sequencer is parked, so a
   // program can never be modified underneath a running fetch.
   assign w_ldEn = ld_we && ((r_state == IDLE) || (r_state == DONE));

   // Next-state and handshake decode. valid comes purely from the state and
   // the IR, which makes it fall together with the asynchronous reset.
   always_comb begin
      w_nextState   = r_state;
      w_valid       = 1'b0;
      w_startAccept = 1'b0;
      w_pcInc       = 1'b0;
      unique case (r_state)
         IDLE, DONE: begin
            if (start) begin
               w_startAccept = 1'b1;
               w_nextState   = FETCH;
            end
         end
         FETCH: begin
            w_nextState = ISSUE;
         end
         ISSUE: begin
            if (w_isHalt) begin
               w_nextState = DONE;
            end else begin
               w_valid = 1'b1;
               if (dec.ready) begin
                  w_pcInc     = 1'b1;
                  w_nextState = FETCH;
               end
            end
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // State, PC and instruction register. The PC wraps naturally at
   // 2**ADDR_W, and the IR is only loaded in FETCH so it stays frozen while
   // the decoder stalls the ISSUE cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_pc    <= '0;
         r_ir    <= '0;
      end else begin
         r_state <= w_nextState;
         if (w_startAccept) begin
            r_pc <= '0;
         end else if (w_pcInc) begin
            r_pc <= r_pc + ADDR_W'(1);
         end
         if (r_state == FETCH) begin
            r_ir <= r_mem[r_pc];
         end
      end
   end

   // Instruction memory write port. It has no reset so a program survives a
   // mid-run reset. A write in the same cycle as start lands on the same edge
   // that enters FETCH, so the following FETCH edge already sees it.
   always_ff @(posedge clk) begin
      if (w_ldEn) begin
         r_mem[ld_addr] <= ld_data;
      end
   end

`ifdef INSTR_COUNT_EN
   logic [15:0] r_retiredCnt;

   // Counts accepted instructions for the current run; HALT never asserts
   // valid, so it is naturally excluded.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_retiredCnt <= '0;
      end else if (w_startAccept) begin
         r_retiredCnt <= '0;
      end else if (w_valid && dec.ready) begin
         r_retiredCnt <= r_retiredCnt + 16'd1;
      end
   end

   assign retired_cnt = r_retiredCnt;
`endif

   // Decoder-facing outputs; opcode and funct are plain slices of the IR.
   assign dec.instr  = r_ir;
   assign dec.opcode = r_ir[31:26];
   assign dec.funct  = r_ir[5:0];
   assign dec.valid  = w_valid;
   assign dec.pc     = r_pc;

   assign busy = (r_state == FETCH) || (r_state == ISSUE);
   assign done = (r_state == DONE);

endmodule
